// File: rtl/ring_johnson_counter_pkg.sv
// Shared constants for the ring/Johnson counter.
// Mode and shift-direction encodings.
package rjc_pkg;

  localparam logic RJC_JOHNSON = 1'b0;
  localparam logic RJC_RING    = 1'b1;
  localparam logic RJC_UP      = 1'b0;
  localparam logic RJC_DOWN    = 1'b1;

endpackage

// File: rtl/rjc_legal_check.sv
// Combinational legality check of a counter state.
// Johnson: at most one adjacent-bit transition; ring: one-hot.
module rjc_legal_check
  import rjc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  logic [WIDTH-1:0] diff;

  always_comb begin
    diff = q ^ {1'b0, q[WIDTH-1:1]};
    if (mode == RJC_RING) begin
      legal = ($countones(q) == 1);
    end else begin
      legal = ($countones(diff[WIDTH-2:0]) <= 1);
    end
  end

endmodule

// File: rtl/ring_johnson_counter.sv
// Ring / Johnson counter with load, direction and mode reseed.
// Optional illegal-state correction: RING_JOHNSON_SELF_CORRECT_EN.
module ring_johnson_counter
  import rjc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] SEED =
    {{(WIDTH-1){1'b0}}, 1'b1};

  logic             mode_q;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = q;
    if (mode_q == RJC_RING) begin
      if (dir == RJC_UP) nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      else               nxt = {q[0], q[WIDTH-1:1]};
    end else begin
      if (dir == RJC_UP) nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
      else               nxt = {~q[0], q[WIDTH-1:1]};
    end
  end

`ifdef RING_JOHNSON_SELF_CORRECT_EN
  logic legal;

  rjc_legal_check #(
    .WIDTH(WIDTH)
  ) u_legal (
    .q    (q),
    .mode (mode_q),
    .legal(legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= SEED;
      tc     <= 1'b0;
      err    <= 1'b0;
      mode_q <= mode;
    end else begin
      mode_q <= mode;
      tc     <= 1'b0;
      err    <= 1'b0;
      if (load) begin
        q <= load_val;
      end else if (mode != mode_q) begin
        q <= SEED;
      end else if (!legal) begin
        q   <= SEED;
        err <= 1'b1;
      end else if (en) begin
        q  <= nxt;
        tc <= (nxt == SEED);
      end
    end
  end
`else
  assign err = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= SEED;
      tc     <= 1'b0;
      mode_q <= mode;
    end else begin
      mode_q <= mode;
      tc     <= 1'b0;
      if (load) begin
        q <= load_val;
      end else if (mode != mode_q) begin
        q <= SEED;
      end else if (en) begin
        q  <= nxt;
        tc <= (nxt == SEED);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Self-checking bench for ring_johnson_counter (WIDTH=4).
// Reference model plus directed literal expectations.
module tb_ring_johnson_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         err;

  int errors = 0;
  int checks = 0;

`ifdef RING_JOHNSON_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  ring_johnson_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .tc      (tc),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: counters as arithmetic on a 4-bit integer
  function automatic int adv(int v, bit rng, bit down);
    int r;
    if (rng) begin
      if (!down) r = (v << 1) | (v >> (W - 1));
      else       r = (v >> 1) | (v << (W - 1));
    end else begin
      if (!down) r = (v << 1) | ((v >= 8) ? 0 : 1);
      else       r = (v >> 1) | ((v % 2 == 1) ? 0 : 8);
    end
    return r % 16;
  endfunction

  function automatic bit is_legal(int v, bit rng);
    int t;
    if (rng) return $countones(v[3:0]) == 1;
    t = 0;
    for (int i = 0; i < W - 1; i++)
      if (((v >> i) % 2) != ((v >> (i + 1)) % 2)) t++;
    return t <= 1;
  endfunction

  int m_q = 1;
  bit m_tc = 0;
  bit m_err = 0;
  bit m_mode_q = 0;

  always @(posedge clk or negedge reset) begin
    int nq;
    bit t;
    bit e;
    if (!reset) begin
      m_q = 1; m_tc = 0; m_err = 0; m_mode_q = mode;
    end else begin
      t = 0; e = 0; nq = m_q;
      if (load) nq = int'(load_val);
      else if (mode != m_mode_q) nq = 1;
      else if (SC && !is_legal(m_q, m_mode_q)) begin
        nq = 1; e = 1;
      end else if (en) begin
        nq = adv(m_q, m_mode_q, dir);
        t = (nq == 1);
      end
      m_q = nq; m_tc = t; m_err = e; m_mode_q = mode;
    end
  end

  always @(negedge clk) begin
    check("model_q", 32'(q), 32'(m_q));
    check("model_tc", 32'(tc), 32'(m_tc));
    check("model_err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic md);
    mode = md; en = 0; load = 0; dir = 0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [W-1:0] jup [8] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110,
                            4'b1100, 4'b1000, 4'b0000, 4'b0001};
  logic [W-1:0] rdn [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    tick();
    tick();
    check("reset_q", 32'(q), 32'h1);
    check("reset_tc", 32'(tc), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    // Johnson up, full period
    do_reset(1'b0);
    en = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("jup_q", 32'(q), 32'(jup[i]));
      check("jup_tc", 32'(tc), (i == 7) ? 32'h1 : 32'h0);
    end

    // Ring down, full period
    do_reset(1'b1);
    dir = 1; en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rdn_q", 32'(q), 32'(rdn[i]));
      check("rdn_tc", 32'(tc), (i == 3) ? 32'h1 : 32'h0);
    end

    // Illegal load in Johnson mode
    do_reset(1'b0);
    load = 1; load_val = 4'b0101; en = 1;
    tick();
    check("ill_load_q", 32'(q), 32'b0101);
    check("ill_load_tc", 32'(tc), 32'h0);
    load = 0;
    tick();
    check("ill_next_q", 32'(q), SC ? 32'b0001 : 32'b1011);
    check("ill_next_err", 32'(err), SC ? 32'h1 : 32'h0);
    check("ill_next_tc", 32'(tc), 32'h0);
    tick();
    check("ill_err_clr", 32'(err), 32'h0);

    // Mode change reseeds
    do_reset(1'b0);
    en = 1;
    tick();
    tick();
    check("mc_pre_q", 32'(q), 32'b0111);
    mode = 1;
    tick();
    check("mc_q", 32'(q), 32'b0001);
    check("mc_tc", 32'(tc), 32'h0);
    check("mc_err", 32'(err), 32'h0);
    tick();
    check("mc_ring_q", 32'(q), 32'b0010);

    // Load beats en, then hold
    mode = 0; load = 1; en = 1; load_val = 4'b0011;
    tick();
    check("prec_q", 32'(q), 32'b0011);
    load = 0; en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q", 32'(q), 32'b0011);
      check("hold_tc", 32'(tc), 32'h0);
    end

    // Async reset mid-cycle
    do_reset(1'b0);
    en = 1;
    for (int i = 0; i < 5; i++) tick();
    check("ar_pre_q", 32'(q), 32'b1100);
    #2;
    reset = 1'b0;
    #1;
    check("ar_q", 32'(q), 32'h1);
    check("ar_tc", 32'(tc), 32'h0);
    check("ar_err", 32'(err), 32'h0);
    tick();
    reset = 1'b1;

    // Mixed traffic against the model
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      load = 1'($urandom_range(0, 7) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      tick();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
